conway_grid_serial: RTL
=======================

# conway_grid_serial

Parametrised successor to the 8x8 serial Game-of-Life core: a WIDTH x HEIGHT cell grid loaded and read through a one-bit serial port and advanced one generation per clock under a 2-bit mode input. New over the fixed 8x8 core: configurable size, optional toroidal (wrap) edges, a saturating generation counter, stable/extinct flags and a frame-complete pulse. It sits directly under the Tiny Tapeout top wrapper, which maps ui_in/uo_out onto its ports.

## Interface
- WIDTH, 8, grid columns (>=3)
- HEIGHT, 8, grid rows (>=3)
- WRAP, 0, 1 = toroidal neighbourhood, 0 = off-grid cells dead
- GEN_W, 8, generation counter width
- LED_DIV, 20, clk_led divider width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- data_in  in  1  serial cell data for LOAD
- mode  in  2  00 HOLD, 01 LOAD, 10 STEP, 11 READ
- data_out  out  1  registered serial cell data for READ
- frame_done  out  1  one-cycle pulse after N=WIDTH*HEIGHT LOAD/READ bits
- gen_count  out  GEN_W  generations since last LOAD, saturating
- stable  out  1  last STEP produced no change
- extinct  out  1  grid all dead (combinational from grid register)
- din_led, dout_led  out  1  registered copies of data_in, data_out
- clk_led  out  1  MSB of free-running LED_DIV counter
- mode_leds  out  2  registered copy of mode

## Operation
- Cell index c = row*WIDTH + col, row-major; grid is an N-bit register.
- mode sampled directly each cycle; new mode acts the same cycle.
- HOLD: grid, counters, flags unchanged; bit counter cleared.
- LOAD: grid <= {data_in, grid[N-1:1]}; after N cycles first bit sits in cell 0. First LOAD cycle after a non-LOAD cycle clears gen_count and stable.
- READ: data_out <= grid[0]; grid rotates {grid[0], grid[N-1:1]}; after N cycles grid restored.
- STEP: grid <= next(grid) every cycle; gen_count += 1 saturating at 2^GEN_W-1; stable <= (next == grid).
- Rule: live with 2 or 3 live neighbours survives; dead with exactly 3 born; else dead. Neighbour count 4-bit, 0..8.
- WRAP=0: neighbours outside grid are 0. WRAP=1: row/col indices modulo HEIGHT/WIDTH.
- Bit counter (clog2(N+1) bits) counts LOAD/READ cycles; cleared whenever mode differs from previous cycle's mode or is HOLD/STEP; on reaching N, frame_done pulses next cycle and counter restarts at 0.
- data_out holds last value outside READ.

## Timing
- Reset values: grid 0, data_out 0, frame_done 0, gen_count 0, stable 0, extinct 1, all LEDs 0, LED counter 0.
- Reset mid-operation aborts immediately; no partial frame survives.
- data_out latency: cell 0 appears the cycle after the first READ edge.
- STEP latency: one cycle per generation; gen_count and stable update on the same edge as grid.
- frame_done: high for exactly one cycle, the cycle after the Nth bit edge; back-to-back frames pulse every N cycles.

## Structure
- Package conway_pkg: mode_e enum (MODE_HOLD, MODE_LOAD, MODE_STEP, MODE_READ), life-rule constants (SURVIVE_LO=2, SURVIVE_HI=3, BIRTH=3).
- Sub-module conway_life_rule: parametrised combinational next-grid generator (WIDTH, HEIGHT, WRAP); top block holds registers, counters and mode decode.

## Test plan
- Reset asserted -> all outputs at reset values, extinct=1, gen_count=0.
- 8x8, load blinker cells 27,28,29, STEP 1 cycle -> cells 20,28,36 live; 2nd STEP -> 27,28,29; gen_count=2, stable=0.
- Load 2x2 block at cells 0,1,8,9, STEP -> grid unchanged, stable=1, gen_count=1.
- Cells 0,1,7 live: WRAP=1 STEP -> cells 0,8,56 live; WRAP=0 STEP -> extinct=1.
- Load pattern, READ 64 cycles -> data_out reproduces loaded stream delayed one cycle, frame_done pulses once at cycle 65; second READ frame identical.
- Reset after 10 LOAD bits -> grid 0; GEN_W=2 with 5 STEP cycles on blinker -> gen_count=3 (saturated).

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types and life-rule helpers for the serial Game-of-Life grid.
// The mode encoding matches the 2-bit mode pins driven by the wrapper.
package conway_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_STEP = 2'b10,
        MODE_READ = 2'b11
    } mode_e;

    localparam logic [3:0] SURVIVE_LO = 4'd2;
    localparam logic [3:0] SURVIVE_HI = 4'd3;
    localparam logic [3:0] BIRTH      = 4'd3;

    function automatic logic [3:0] count_live(input logic [7:0] nb);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, nb[i]};
        end
        return n;
    endfunction

    function automatic logic next_state(input logic alive, input logic [3:0] n);
        if (alive) begin
            return (n >= SURVIVE_LO) && (n <= SURVIVE_HI);
        end
        return n == BIRTH;
    endfunction

endpackage

// File: rtl/conway_grid_serial_if.sv
// Serial cell port: mode and data_in towards the grid, data_out and the
// frame-complete pulse back to the host.
interface conway_grid_serial_if;

    logic                data_in;
    conway_pkg::mode_e   mode;
    logic                data_out;
    logic                frame_done;

    modport master (
        output data_in,
        output mode,
        input  data_out,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  mode,
        output data_out,
        output frame_done
    );

endinterface

// File: rtl/conway_life_rule.sv
// Combinational next-generation generator for a WIDTH x HEIGHT grid stored
// row-major (cell = row*WIDTH + col), with optional toroidal edges.
module conway_life_rule
    import conway_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int WRAP   = 0
) (
    input  logic [WIDTH*HEIGHT-1:0] grid_i,
    output logic [WIDTH*HEIGHT-1:0] next_o
);

    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            logic [7:0] nb;

            // Neighbour positions walk the 3x3 window, skipping the centre (4).
            for (genvar k = 0; k < 8; k++) begin : g_nb
                localparam int  POS    = (k < 4) ? k : k + 1;
                localparam int  RR_RAW = r + POS / 3 - 1;
                localparam int  CC_RAW = c + POS % 3 - 1;
                localparam bit  INSIDE = (RR_RAW >= 0) && (RR_RAW < HEIGHT) &&
                                         (CC_RAW >= 0) && (CC_RAW < WIDTH);
                localparam int  RR     = (RR_RAW + HEIGHT) % HEIGHT;
                localparam int  CC     = (CC_RAW + WIDTH) % WIDTH;

                if (INSIDE || (WRAP != 0)) begin : g_live
                    assign nb[k] = grid_i[RR*WIDTH + CC];
                end else begin : g_dead
                    assign nb[k] = 1'b0;
                end
            end

            assign next_o[r*WIDTH + c] = next_state(grid_i[r*WIDTH + c], count_live(nb));
        end
    end

endmodule

// File: rtl/conway_grid_serial.sv
// Serial-loaded Game-of-Life grid: LOAD/READ shift one cell per clock, STEP
// advances one generation per clock, with generation count and status flags.
module conway_grid_serial
    import conway_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int HEIGHT  = 8,
    parameter int WRAP    = 0,
    parameter int GEN_W   = 8,
    parameter int LED_DIV = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    conway_grid_serial_if.slave   sif,
    output logic [GEN_W-1:0]      gen_count,
    output logic                  stable,
    output logic                  extinct,
    output logic                  din_led,
    output logic                  dout_led,
    output logic                  clk_led,
    output logic [1:0]            mode_leds
);

    localparam int N     = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(N + 1);

    logic [N-1:0]       grid_q, grid_d, grid_next;
    logic               data_out_q, data_out_d;
    logic               frame_done_q, frame_done_d;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic               stable_q, stable_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               frame_end;
    mode_e              mode_q;
    logic               din_led_q, dout_led_q;
    logic [LED_DIV-1:0] led_cnt_q;

    conway_life_rule #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .WRAP   (WRAP)
    ) u_rule (
        .grid_i (grid_q),
        .next_o (grid_next)
    );

    // A mode change restarts the frame, so the first LOAD/READ cycle counts as bit 1.
    assign cnt_inc   = ((sif.mode != mode_q) ? '0 : bit_cnt_q) + CNT_W'(1);
    assign frame_end = (cnt_inc == CNT_W'(N));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; that is what keeps this block free of inferred latches.
        grid_d       = grid_q;
        data_out_d   = data_out_q;
        frame_done_d = 1'b0;
        gen_d        = gen_q;
        stable_d     = stable_q;
        bit_cnt_d    = '0;

        case (sif.mode)
            MODE_LOAD: begin
                grid_d = {sif.data_in, grid_q[N-1:1]};
                if (mode_q != MODE_LOAD) begin
                    gen_d    = '0;
                    stable_d = 1'b0;
                end
                bit_cnt_d    = frame_end ? '0 : cnt_inc;
                frame_done_d = frame_end;
            end
            MODE_READ: begin
                data_out_d   = grid_q[0];
                grid_d       = {grid_q[0], grid_q[N-1:1]};
                bit_cnt_d    = frame_end ? '0 : cnt_inc;
                frame_done_d = frame_end;
            end
            MODE_STEP: begin
                grid_d   = grid_next;
                stable_d = (grid_next == grid_q);
                if (gen_q != '1) begin
                    gen_d = gen_q + GEN_W'(1);
                end
            end
            MODE_HOLD: ;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grid_q       <= '0;
            data_out_q   <= 1'b0;
            frame_done_q <= 1'b0;
            gen_q        <= '0;
            stable_q     <= 1'b0;
            bit_cnt_q    <= '0;
            mode_q       <= MODE_HOLD;
            din_led_q    <= 1'b0;
            dout_led_q   <= 1'b0;
            led_cnt_q    <= '0;
        end else begin
            grid_q       <= grid_d;
            data_out_q   <= data_out_d;
            frame_done_q <= frame_done_d;
            gen_q        <= gen_d;
            stable_q     <= stable_d;
            bit_cnt_q    <= bit_cnt_d;
            mode_q       <= sif.mode;
            din_led_q    <= sif.data_in;
            dout_led_q   <= data_out_q;
            led_cnt_q    <= led_cnt_q + LED_DIV'(1);
        end
    end

    assign sif.data_out   = data_out_q;
    assign sif.frame_done = frame_done_q;
    assign gen_count      = gen_q;
    assign stable         = stable_q;
    assign extinct        = ~|grid_q;
    assign din_led        = din_led_q;
    assign dout_led       = dout_led_q;
    assign clk_led        = led_cnt_q[LED_DIV-1];
    assign mode_leds      = mode_q;

endmodule
